demux_1_4_stream: RTL and testbench

//  Stream demultiplexer: one input valid/ready stream carries a 2-bit

---
 rtl/demux_pkg.sv | 22 ++
 rtl/stream_fifo_small.sv | 83 ++++++++
 rtl/demux_1_4_stream.sv | 67 ++++++
 tb/tb_demux_1_4_stream.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared definitions for the 1:4 stream demultiplexer.
//                N_OUT   - number of output channels
//                dest_t  - destination tag type carried with each input word
//                lvl_w() - width of an occupancy counter for a given depth
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int N_OUT = 4;

    typedef logic [1:0] dest_t;

    // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_small.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_small
//  Description : Small synchronous FIFO with a per-FIFO occupancy counter.
//                The counter, not the pointers, decides full/empty.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                push, push_data     - write request and word (ignored if full)
//                pop                 - read request (ignored if empty)
//                head                - entry at the read pointer
//                empty, full, level  - status and occupancy 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_small
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic                      empty,
    output logic                      full,
    output logic [lvl_w(DEPTH)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic [LVL_W-1:0] count_d;

    logic w_do_push;
    logic w_do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == LVL_W'(DEPTH));
    assign level = count_q;
    // After a pop empties the FIFO the read pointer moves on, so head shows
    // whatever that slot last held (stale) until it is written again.
    assign head  = mem_q[rd_ptr_q];

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_1_4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_4_stream
//  Description : Routes one tagged valid/ready input stream to four output
//                streams, each behind its own small FIFO so a stalled
//                consumer only blocks words addressed to it.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                in_valid/in_ready    - input handshake
//                in_data, in_dest     - input word and destination channel
//                out_valid/out_ready  - per-channel handshake (bit i = ch i)
//                out_data             - ch i at [i*W +: W]
//                out_level            - ch i occupancy, same packing
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [W-1:0]                    in_data,
    input  dest_t                           in_dest,
    output logic [N_OUT-1:0]                out_valid,
    input  logic [N_OUT-1:0]                out_ready,
    output logic [N_OUT*W-1:0]              out_data,
    output logic [N_OUT*lvl_w(DEPTH)-1:0]   out_level
);

    localparam int LVL_W = lvl_w(DEPTH);

    logic [N_OUT-1:0] w_full;
    logic [N_OUT-1:0] w_empty;
    logic [N_OUT-1:0] w_push;
    logic [N_OUT-1:0] w_pop;

    // Depends only on the selected FIFO's full flag, never on out_ready, so a
    // same-cycle pop on a full FIFO does not open the input that cycle.
    // Held low while reset is asserted.
    assign in_ready  = rst_n & ~w_full[in_dest];
    assign out_valid = ~w_empty;

    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        assign w_push[i] = in_valid & in_ready & (in_dest == dest_t'(i));
        assign w_pop[i]  = ~w_empty[i] & out_ready[i];

        stream_fifo_small #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (w_push[i]),
            .push_data (in_data),
            .pop       (w_pop[i]),
            .head      (out_data[i*W +: W]),
            .empty     (w_empty[i]),
            .full      (w_full[i]),
            .level     (out_level[i*LVL_W +: LVL_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1_4_stream
//  Description : Self-checking bench for demux_1_4_stream. A per-channel queue
//                model is compared against the outputs every falling edge;
//                directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_4_stream;

    localparam int W     = 4;
    localparam int DEPTH = 2;
    localparam int LW    = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_dest;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*W-1:0]  out_data;
    logic [4*LW-1:0] out_level;

    int n_chk;
    int n_pass;

    demux_1_4_stream #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_level (out_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: one queue per channel ----------------
    logic [W-1:0] mq [4][$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
        end else begin
            int sz [4];
            for (int c = 0; c < 4; c++) sz[c] = mq[c].size();
            for (int c = 0; c < 4; c++)
                if (out_ready[c] && sz[c] > 0) void'(mq[c].pop_front());
            // Acceptance uses the occupancy before this edge's pops.
            if (in_valid && sz[in_dest] < DEPTH) mq[in_dest].push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(out_valid), 32'h0);
            check("rst_level", 32'(out_level), 32'h0);
            check("rst_data",  32'(out_data),  32'h0);
            check("rst_ready", 32'(in_ready),  32'h0);
        end else begin
            for (int c = 0; c < 4; c++) begin
                check("model_valid", 32'(out_valid[c]), 32'(mq[c].size() != 0));
                check("model_level", 32'(out_level[c*LW +: LW]), 32'(mq[c].size()));
                if (mq[c].size() != 0)
                    check("model_data", 32'(out_data[c*W +: W]), 32'(mq[c][0]));
            end
            check("model_in_ready", 32'(in_ready), 32'(mq[in_dest].size() < DEPTH));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic [W-1:0] x,
                         input logic [3:0] r);
        in_valid  = v;
        in_dest   = d;
        in_data   = x;
        out_ready = r;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        step();
        step();
        check("reset_in_ready", 32'(in_ready), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'h1);

        // 1. single word to channel 2
        drive(1'b1, 2'd2, 4'hA, 4'hF);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        #1;
        check("t1_valid", 32'(out_valid), 32'h4);
        check("t1_data2", 32'(out_data[11:8]), 32'hA);
        check("t1_level", 32'(out_level), 32'h10);
        step();
        check("t1_drained", 32'(out_valid), 32'h0);

        // 2. back-pressure on channel 1
        drive(1'b1, 2'd1, 4'h1, 4'h0); step();
        drive(1'b1, 2'd1, 4'h2, 4'h0); step();
        drive(1'b1, 2'd1, 4'h3, 4'h0); #1;
        check("t2_full_ready", 32'(in_ready), 32'h0);
        check("t2_level1", 32'(out_level[3:2]), 32'h2);
        check("t2_head", 32'(out_data[7:4]), 32'h1);
        out_ready = 4'b0010;
        #1;
        check("t2_ready_indep_of_pop", 32'(in_ready), 32'h0);
        step();
        check("t2_pop1_head", 32'(out_data[7:4]), 32'h2);
        check("t2_pop1_ready", 32'(in_ready), 32'h1);
        step();
        check("t2_third_head", 32'(out_data[7:4]), 32'h3);
        check("t2_third_level", 32'(out_level[3:2]), 32'h1);
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        step();

        // 3. channel 0 full and stalled, channel 3 still flows
        drive(1'b1, 2'd0, 4'h5, 4'h0); step();
        drive(1'b1, 2'd0, 4'h6, 4'h0); step();
        drive(1'b1, 2'd3, 4'h7, 4'h0); #1;
        check("t3_ready_ch3", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'h0); #1;
        check("t3_valid", 32'(out_valid), 32'h9);
        check("t3_data3", 32'(out_data[15:12]), 32'h7);
        step();
        check("t3_ch0_stable", 32'(out_data[3:0]), 32'h5);
        out_ready = 4'hF;
        step(); step(); step();

        // 4. simultaneous push and pop on channel 2 at level 1
        drive(1'b1, 2'd2, 4'h0, 4'h0); step();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 2'd2, W'(k), 4'b0100);
            step();
            check("t4_level", 32'(out_level[5:4]), 32'h1);
            check("t4_data", 32'(out_data[11:8]), 32'(k));
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        step(); step();

        // 5. random traffic, checked by the model every cycle
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        step(); step(); step();

        // 6. asynchronous reset mid-burst with levels 2,1,0,2
        drive(1'b1, 2'd0, 4'h1, 4'h0); step();
        drive(1'b1, 2'd0, 4'h2, 4'h0); step();
        drive(1'b1, 2'd1, 4'h3, 4'h0); step();
        drive(1'b1, 2'd3, 4'h4, 4'h0); step();
        drive(1'b1, 2'd3, 4'h5, 4'h0); step();
        drive(1'b0, 2'd0, 4'h0, 4'h0); #1;
        check("t6_pre_level", 32'(out_level), 32'h86);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        check("t6_rst_level", 32'(out_level), 32'h0);
        check("t6_rst_ready", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 4'h9, 4'h0);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'h0); #1;
        check("t6_new_valid", 32'(out_valid), 32'h2);
        check("t6_new_data", 32'(out_data[7:4]), 32'h9);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
